// File: rtl/fetch_queue_if.sv
// Fetch-stage handshake bundle: redirect controls, instruction-memory port and queue head.
interface fetch_queue_if #(
  parameter int unsigned WORD  = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            stall;
  logic            branch_taken;
  logic            jump_taken;
  logic [WORD-1:0] branch_offset;
  logic [WORD-1:0] new_addr;
  logic [WORD-1:0] imem_addr;
  logic [WORD-1:0] imem_data;
  logic [WORD-1:0] PC;
  logic [WORD-1:0] instruction;
  logic            valid;
  logic [CW-1:0]   count;

  // The fetch stage side.
  modport master (
    input  stall, branch_taken, jump_taken, branch_offset, new_addr, imem_data,
    output imem_addr, PC, instruction, valid, count
  );

  // The decode / memory side.
  modport slave (
    output stall, branch_taken, jump_taken, branch_offset, new_addr, imem_data,
    input  imem_addr, PC, instruction, valid, count
  );
endinterface

// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage: owns the fetch PC, reads a combinational instruction
// memory and buffers {PC, instruction} pairs in a DEPTH-entry circular queue.
// Optional feature macro FETCH_BYPASS_EN: an empty queue presents the current
// fetch directly to decode for zero-cycle latency after a flush.
module fetch_queue_stage #(
  parameter int unsigned     WORD       = 32,
  parameter int unsigned     DEPTH      = 4,
  parameter logic [WORD-1:0] RESET_PC   = '0,
  parameter int unsigned     INC        = 4,
  parameter int unsigned     ADDR_SHIFT = 2
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WORD-1:0] fpc, fpc_nxt;
  logic [WORD-1:0] pc_mem  [DEPTH];
  logic [WORD-1:0] ins_mem [DEPTH];
  logic [PW-1:0]   rd_ptr, rd_nxt, wr_ptr, wr_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            empty, redirect, valid_c, pop, deq, push, wr_en;
  logic [WORD-1:0] base, target;

  // Head presentation and handshake decode.
  always_comb begin
    empty    = (cnt == '0);
    redirect = bus.jump_taken | bus.branch_taken;
`ifdef FETCH_BYPASS_EN
    valid_c         = ~rst | ~empty;
    bus.PC          = empty ? (rst ? '0 : fpc)           : pc_mem[rd_ptr];
    bus.instruction = empty ? (rst ? '0 : bus.imem_data) : ins_mem[rd_ptr];
`else
    valid_c         = ~empty;
    bus.PC          = empty ? '0 : pc_mem[rd_ptr];
    bus.instruction = empty ? '0 : ins_mem[rd_ptr];
`endif
    pop  = valid_c & ~bus.stall & ~redirect;
    // A pop from an empty queue can only be a bypassed fetch: it is consumed, not stored.
    deq   = pop & ~empty;
    push  = ~redirect & ((cnt < CW'(DEPTH)) | pop);
    wr_en = push & ~(empty & pop);
  end

  assign bus.valid     = valid_c;
  assign bus.count     = cnt;
  assign bus.imem_addr = fpc;

  // Redirect target: jump wins; branch is relative to the head (fpc when nothing is held).
  always_comb begin
    base   = empty ? fpc : pc_mem[rd_ptr];
    target = bus.jump_taken ? (bus.new_addr << ADDR_SHIFT)
                            : base + (bus.branch_offset << ADDR_SHIFT);
  end

  // Next-state for fetch PC, pointers and occupancy.
  always_comb begin
    fpc_nxt = fpc;
    rd_nxt  = rd_ptr;
    wr_nxt  = wr_ptr;
    cnt_nxt = cnt;
    if (redirect) begin
      fpc_nxt = target;
      rd_nxt  = '0;
      wr_nxt  = '0;
      cnt_nxt = '0;
    end else begin
      if (push)  fpc_nxt = fpc + WORD'(INC);
      if (wr_en) wr_nxt  = wr_ptr + PW'(1);
      if (deq)   rd_nxt  = rd_ptr + PW'(1);
      cnt_nxt = cnt + CW'(wr_en) - CW'(deq);
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc    <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      fpc    <= fpc_nxt;
      rd_ptr <= rd_nxt;
      wr_ptr <= wr_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // Queue storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      pc_mem[wr_ptr]  <= fpc;
      ins_mem[wr_ptr] <= bus.imem_data;
    end
  end
endmodule

// File: tb/tb_fetch_queue_stage.sv
// Self-checking bench for fetch_queue_stage: directed scenarios plus random
// redirect/stall traffic against a queue-based reference model.
module tb_fetch_queue_stage;
  localparam int unsigned     WORD     = 32;
  localparam int unsigned     DEPTH    = 4;
  localparam logic [31:0]     RESET_PC = 32'h0;
  localparam int unsigned     INC      = 4;

`ifdef FETCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  ent_t        mq[$];
  logic [31:0] m_fpc;
  bit          m_ok = 1'b0;

  fetch_queue_if #(.WORD(WORD), .DEPTH(DEPTH)) bus ();

  fetch_queue_stage #(
    .WORD(WORD), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .INC(INC), .ADDR_SHIFT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Memory word k holds 0x1000 + k.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  assign bus.imem_data = mem_word(bus.imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Outputs the model predicts for the current state and inputs.
  task automatic compare_outputs();
    logic        ev;
    logic [31:0] ep, ei;
    if (!m_ok) return;
    if (mq.size() > 0) begin
      ev = 1'b1; ep = mq[0].pc; ei = mq[0].ins;
    end else if (BYPASS && !rst) begin
      ev = 1'b1; ep = m_fpc; ei = mem_word(m_fpc);
    end else begin
      ev = 1'b0; ep = 32'h0; ei = 32'h0;
    end
    check("model_valid", 32'(bus.valid), 32'(ev));
    check("model_pc", bus.PC, ep);
    check("model_instr", bus.instruction, ei);
    check("model_count", 32'(bus.count), mq.size());
    check("model_imem_addr", bus.imem_addr, m_fpc);
  endtask

  // Architectural effect of one clock edge.
  task automatic model_step(input logic r, s, bt, jt, input logic [31:0] off, na);
    logic [31:0] base;
    if (r) begin
      mq.delete();
      m_fpc = RESET_PC;
      m_ok  = 1'b1;
      return;
    end
    if (jt || bt) begin
      base = (mq.size() > 0) ? mq[0].pc : m_fpc;
      m_fpc = jt ? na * 4 : base + off * 4;
      mq.delete();
      return;
    end
    if ((mq.size() > 0 || BYPASS) && !s) begin
      if (mq.size() > 0) begin
        void'(mq.pop_front());
      end else begin
        m_fpc += INC;
        return;
      end
    end
    if (mq.size() < DEPTH) begin
      mq.push_back('{m_fpc, mem_word(m_fpc)});
      m_fpc += INC;
    end
  endtask

  task automatic step(input logic r, s, bt, jt, input logic [31:0] off, na);
    @(negedge clk);
    rst               = r;
    bus.stall         = s;
    bus.branch_taken  = bt;
    bus.jump_taken    = jt;
    bus.branch_offset = off;
    bus.new_addr      = na;
    #1;
    compare_outputs();
    @(posedge clk);
    model_step(r, s, bt, jt, off, na);
    #2;
  endtask

  task automatic run(input int n, input logic s);
    repeat (n) step(1'b0, s, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic reset2();
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic peek(input string tag, input logic v, input logic [31:0] pc,
                      input logic [31:0] ins, input int cnt);
    check({tag, "_valid"}, 32'(bus.valid), 32'(v));
    check({tag, "_pc"}, bus.PC, pc);
    check({tag, "_instr"}, bus.instruction, ins);
    check({tag, "_count"}, 32'(bus.count), 32'(cnt));
  endtask

  initial begin
    rst               = 1'b1;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.jump_taken    = 1'b0;
    bus.branch_offset = '0;
    bus.new_addr      = '0;

    // Reset then run.
    reset2();
`ifndef FETCH_BYPASS_EN
    peek("reset", 1'b0, 32'h0, 32'h0, 0);
    check("reset_imem_addr", bus.imem_addr, 32'h0);
`endif
    for (int k = 0; k < 4; k++) begin
      run(1, 1'b0);
`ifndef FETCH_BYPASS_EN
      peek("run", 1'b1, 32'(4 * k), 32'h1000 + 32'(k), 1);
`endif
    end

    // Fill to full under stall, then drain.
    reset2();
    run(8, 1'b1);
`ifndef FETCH_BYPASS_EN
    peek("full", 1'b1, 32'h0, 32'h1000, 4);
    check("full_imem_addr", bus.imem_addr, 32'd16);
`endif
    for (int k = 1; k <= 5; k++) begin
      run(1, 1'b0);
`ifndef FETCH_BYPASS_EN
      peek("drain", 1'b1, 32'(4 * k), 32'h1000 + 32'(k), 4);
`endif
    end

    // Branch back by two words from head PC 8, then a wrapping offset.
    reset2();
    run(3, 1'b0);
`ifndef FETCH_BYPASS_EN
    check("br_head_pc", bus.PC, 32'd8);
`endif
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0);
`ifndef FETCH_BYPASS_EN
    peek("br_flush", 1'b0, 32'h0, 32'h0, 0);
    check("br_target", bus.imem_addr, 32'h0);
`endif
    run(1, 1'b0);
`ifndef FETCH_BYPASS_EN
    peek("br_head", 1'b1, 32'h0, 32'h1000, 1);
`endif
    run(2, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h3FFF_FFFF, 32'h0);
`ifndef FETCH_BYPASS_EN
    check("br_wrap_target", bus.imem_addr, 32'd4);
`endif
    run(1, 1'b0);
`ifndef FETCH_BYPASS_EN
    peek("br_wrap_head", 1'b1, 32'd4, 32'h1001, 1);
`endif

    // Jump beats branch and stall.
    step(1'b0, 1'b1, 1'b1, 1'b1, $urandom, 32'h40);
`ifndef FETCH_BYPASS_EN
    peek("jmp_flush", 1'b0, 32'h0, 32'h0, 0);
    check("jmp_target", bus.imem_addr, 32'h100);
`endif
    run(1, 1'b0);
`ifndef FETCH_BYPASS_EN
    peek("jmp_head", 1'b1, 32'h100, 32'h1040, 1);
`endif

    // Reset with a partly full queue.
    reset2();
    run(3, 1'b1);
`ifndef FETCH_BYPASS_EN
    check("mid_count", 32'(bus.count), 32'd3);
`endif
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("mid_rst_count", 32'(bus.count), 32'd0);
    check("mid_rst_imem_addr", bus.imem_addr, RESET_PC);
    for (int k = 0; k < 4; k++) begin
      run(1, 1'b0);
`ifndef FETCH_BYPASS_EN
      peek("restart", 1'b1, 32'(4 * k), 32'h1000 + 32'(k), 1);
`endif
    end

    // Cycle right after a jump to 0x40.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h10);
`ifdef FETCH_BYPASS_EN
    peek("bypass", 1'b1, 32'h40, 32'h1010, 0);
`else
    peek("bypass", 1'b0, 32'h0, 32'h0, 0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      logic        r, s, bt, jt;
      logic [31:0] off;
      r   = ($urandom_range(0, 99) == 0);
      s   = ($urandom_range(0, 99) < 35);
      bt  = ($urandom_range(0, 99) < 8);
      jt  = ($urandom_range(0, 99) < 4);
      off = $urandom_range(0, 1) ? (32'($urandom_range(0, 16)) - 32'd8) : $urandom;
      step(r, s, bt, jt, off, $urandom);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
